simple_mod_reduce: RTL and testbench
====================================

SIMPLE_MOD_REDUCE -- requirements
Module: simple_mod_reduce

Interface
REQ-001 Parameter input_size, default 1024, modulus and result width in bits.
REQ-002 Parameter product_size, default 2*input_size, width of the product to be reduced.
REQ-003 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 product_in  input  product_size  dividend, e.g. the squarer/multiplier result.
REQ-006 modulus_in  input  input_size  modulus M.
REQ-007 ready_in  input  1  start request, sampled on rising edge.
REQ-008 result  output  input_size  product_in mod modulus_in.
REQ-009 busy_out  output  1  high while a reduction is in progress.
REQ-010 valid_out  output  1  one-cycle pulse marking result valid.
REQ-011 error_out  output  1  high with valid_out when modulus was zero.

Function
REQ-012 Algorithm: restoring bit-serial long division, one product bit per cycle, MSB first; remainder register R is input_size+1 bits wide.
REQ-013 States: IDLE, REDUCE; any unencoded state returns to IDLE with busy_out=0, valid_out=0.
REQ-014 IDLE: valid_out, error_out driven 0 in every IDLE cycle except the pulse of REQ-019/REQ-020.
REQ-015 IDLE and ready_in=1 at an edge: latch product_in and modulus_in into internal registers, clear R, load bit counter to product_size-1, busy_out<=1, go to REDUCE.
REQ-016 Inputs are sampled only at the accept edge; later changes to product_in/modulus_in have no effect on the running operation.
REQ-017 REDUCE, each edge: R' = (R<<1) | current product bit; if R' >= M then R <= R'-M else R <= R'; decrement counter.
REQ-018 Latency fixed and data-independent (constant time): exactly product_size REDUCE cycles, no early exit on leading zeros.
REQ-019 Edge processing bit 0: result <= final R[input_size-1:0], valid_out<=1, busy_out<=0, state<=IDLE; valid_out is high for exactly one cycle, product_size cycles after the accept edge.
REQ-020 Zero modulus at accept: no REDUCE; next edge result<=0, error_out<=1, valid_out<=1, busy_out<=0, stay IDLE.
REQ-021 result holds its last value until the next valid_out pulse or reset.
REQ-022 ready_in while busy_out=1 is ignored; no queueing.
REQ-023 ready_in=1 in the valid_out cycle starts a new operation (back-to-back, zero idle cycles).
REQ-024 Invariant: R < M after every REDUCE edge; final result < M.
REQ-025 modulus_in=1 yields result 0; product_in < modulus_in yields result = product_in.

Reset
REQ-026 rst_in=0 asynchronously forces: state IDLE, busy_out=0, valid_out=0, error_out=0, result=0, R=0, counter=0.
REQ-027 Reset mid-REDUCE aborts the operation; no valid_out pulse is produced for it after release.
REQ-028 First ready_in honoured at the first rising edge with rst_in=1.

Verification (input_size=8, product_size=16)
REQ-029 product 16'h1234, modulus 8'd7, ready pulse -> valid_out 16 cycles later, result 8'd5, error_out 0.
REQ-030 product 16'hFFFF, modulus 8'hFF -> result 8'd0; product 16'h0005, modulus 8'hFF -> result 8'd5.
REQ-031 modulus 8'd0 -> next cycle valid_out=1, error_out=1, result 0, busy_out never high.
REQ-032 ready_in held high continuously with a new operand each accept -> back-to-back pulses every 16 cycles, each result correct; ready_in pulses while busy ignored.
REQ-033 rst_in low at cycle 8 of an operation -> all outputs 0 immediately, no valid_out after release, next request completes correctly.
REQ-034 Random operands, 1000 trials, checked against a reference model: result = product mod modulus, latency always 16.

Source files
------------

// File: rtl/simple_mod_reduce_if.sv
// Operand/result bundle for simple_mod_reduce. The requester drives the
// operands and start strobe through the master modport; the reducer returns
// the remainder and status flags through the slave modport.
`timescale 1ns/1ps
interface simple_mod_reduce_if #(
  parameter int unsigned input_size   = 1024,
  parameter int unsigned product_size = 2 * input_size
);
  logic [product_size-1:0] product_in;
  logic [input_size-1:0]   modulus_in;
  logic                    ready_in;
  logic [input_size-1:0]   result;
  logic                    busy_out;
  logic                    valid_out;
  logic                    error_out;

  modport master (
    output product_in, modulus_in, ready_in,
    input  result, busy_out, valid_out, error_out
  );

  modport slave (
    input  product_in, modulus_in, ready_in,
    output result, busy_out, valid_out, error_out
  );
endinterface

// File: rtl/simple_mod_reduce.sv
// Constant-time modular reduction: product mod modulus by restoring
// bit-serial long division, one product bit per clock, MSB first.
// A reduction takes exactly product_size cycles regardless of operand
// values, so no timing information leaks about the data.
`timescale 1ns/1ps
module simple_mod_reduce #(
  parameter int unsigned input_size   = 1024,
  parameter int unsigned product_size = 2 * input_size
) (
  input logic               clk_in,
  input logic               rst_in,
  simple_mod_reduce_if.slave bus
);

  localparam int unsigned CntW = (product_size > 1) ? $clog2(product_size) : 1;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StReduce = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [product_size-1:0] prod_q, prod_d;
  logic [input_size-1:0]   mod_q, mod_d;
  logic [input_size:0]     r_q, r_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [input_size-1:0]   result_q, result_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic                    error_q, error_d;

  // One division step. R < M always holds, so the shifted remainder fits in
  // input_size+1 bits; its top bit still takes part in the compare.
  logic [input_size+1:0] r_wide;
  logic                  r_ge;
  logic [input_size:0]   r_sub;
  logic [input_size:0]   r_step;

  always_comb begin
    r_wide = {r_q, prod_q[product_size-1]};
    r_ge   = (r_wide >= {2'b00, mod_q});
    r_sub  = r_wide[input_size:0] - {1'b0, mod_q};
    r_step = r_ge ? r_sub : r_wide[input_size:0];
  end

  // Next-state and output decode; status strobes default low every cycle.
  always_comb begin
    state_d  = state_q;
    prod_d   = prod_q;
    mod_d    = mod_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = 1'b0;
    valid_d  = 1'b0;
    error_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.ready_in) begin
          if (bus.modulus_in == '0) begin
            // Division by zero: report immediately, never enter REDUCE.
            result_d = '0;
            valid_d  = 1'b1;
            error_d  = 1'b1;
          end else begin
            prod_d  = bus.product_in;
            mod_d   = bus.modulus_in;
            r_d     = '0;
            cnt_d   = CntW'(product_size - 1);
            busy_d  = 1'b1;
            state_d = StReduce;
          end
        end
      end

      StReduce: begin
        prod_d = {prod_q[product_size-2:0], 1'b0};
        r_d    = r_step;
        if (cnt_q == '0) begin
          result_d = r_step[input_size-1:0];
          valid_d  = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= StIdle;
      prod_q   <= '0;
      mod_q    <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prod_q   <= prod_d;
      mod_q    <= mod_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.busy_out  = busy_q;
  assign bus.valid_out = valid_q;
  assign bus.error_out = error_q;

endmodule

// File: tb/tb_simple_mod_reduce.sv
// Directed and random checks of simple_mod_reduce (8-bit modulus, 16-bit
// product) against a plain-arithmetic reference: result = product % modulus.
`timescale 1ns/1ps
module tb_simple_mod_reduce;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  simple_mod_reduce_if #(.input_size(8), .product_size(16)) bus ();

  simple_mod_reduce #(.input_size(8), .product_size(16)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request; operands are scrambled after acceptance and a stray ready
  // pulse is issued while busy, neither of which may disturb the result.
  task automatic run_op(input logic [15:0] p, input logic [7:0] m, input string tag);
    int         n;
    int         exp_lat;
    logic [7:0] exp_r;
    logic       exp_e;
    logic       busy_ok;
    if (m == 8'd0) begin
      exp_lat = 0;
      exp_r   = 8'd0;
      exp_e   = 1'b1;
    end else begin
      exp_lat = 16;
      exp_r   = 8'(p % m);
      exp_e   = 1'b0;
    end
    bus.product_in = p;
    bus.modulus_in = m;
    bus.ready_in   = 1'b1;
    @(posedge clk_in); #1;
    bus.ready_in   = 1'b0;
    bus.product_in = 16'($urandom);
    bus.modulus_in = 8'($urandom);
    n       = 0;
    busy_ok = 1'b1;
    while (!bus.valid_out && n < 40) begin
      if (bus.busy_out !== 1'b1) busy_ok = 1'b0;
      bus.ready_in = (n == 5);
      @(posedge clk_in); #1;
      n++;
    end
    bus.ready_in = 1'b0;
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_result"}, bus.result, exp_r);
    check({tag, "_error"}, bus.error_out, exp_e);
    check({tag, "_busy_during"}, busy_ok, 1'b1);
    check({tag, "_busy_at_valid"}, bus.busy_out, 1'b0);
    @(posedge clk_in); #1;
    check({tag, "_pulse_one_cycle"}, bus.valid_out, 1'b0);
    check({tag, "_result_held"}, bus.result, exp_r);
  endtask

  logic [15:0] bp [5];
  logic [7:0]  bm [5];

  initial begin
    int         n;
    int         seen;
    logic [15:0] rp;
    logic [7:0]  rm;

    bus.product_in = '0;
    bus.modulus_in = '0;
    bus.ready_in   = 1'b0;
    #1 rst_in = 1'b0;
    #20;
    check("reset_result", bus.result, 8'd0);
    check("reset_busy", bus.busy_out, 1'b0);
    check("reset_valid", bus.valid_out, 1'b0);
    check("reset_error", bus.error_out, 1'b0);
    @(posedge clk_in); #1;
    rst_in = 1'b1;

    // Directed cases.
    run_op(16'h1234, 8'd7, "p1234_m7");
    run_op(16'hFFFF, 8'hFF, "pFFFF_mFF");
    run_op(16'h0005, 8'hFF, "p0005_mFF");
    run_op(16'hBEEF, 8'd1, "mod_one");
    run_op(16'h0003, 8'h10, "p_lt_m");
    run_op(16'h8001, 8'h80, "p8001_m80");
    run_op(16'h4321, 8'd0, "mod_zero");

    // Back-to-back with ready held high throughout.
    for (int i = 0; i < 5; i++) begin
      bp[i] = 16'($urandom);
      bm[i] = 8'($urandom_range(1, 255));
    end
    bus.product_in = bp[0];
    bus.modulus_in = bm[0];
    bus.ready_in   = 1'b1;
    @(posedge clk_in); #1;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        bus.product_in = bp[k+1];
        bus.modulus_in = bm[k+1];
      end
      n = 0;
      while (!bus.valid_out && n < 40) begin
        @(posedge clk_in); #1;
        n++;
      end
      check("b2b_latency", n, 16);
      check("b2b_result", bus.result, 8'(bp[k] % bm[k]));
      if (k == 4) bus.ready_in = 1'b0;
      @(posedge clk_in); #1;
    end
    check("b2b_idle_after", bus.busy_out, 1'b0);

    // Reset in the middle of a reduction.
    bus.product_in = 16'hA5A5;
    bus.modulus_in = 8'd13;
    bus.ready_in   = 1'b1;
    @(posedge clk_in); #1;
    bus.ready_in = 1'b0;
    repeat (8) begin
      @(posedge clk_in); #1;
    end
    #2 rst_in = 1'b0;
    #1;
    check("midrst_result", bus.result, 8'd0);
    check("midrst_busy", bus.busy_out, 1'b0);
    check("midrst_valid", bus.valid_out, 1'b0);
    check("midrst_error", bus.error_out, 1'b0);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk_in); #1;
      if (bus.valid_out || bus.busy_out) seen++;
    end
    check("midrst_no_pulse", seen, 0);
    run_op(16'hA5A5, 8'd13, "after_rst");

    // Random trials.
    for (int t = 0; t < 1000; t++) begin
      rp = 16'($urandom);
      rm = ($urandom_range(0, 31) == 0) ? 8'd0 : 8'($urandom);
      run_op(rp, rm, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
